riscv_imem_loader: RTL

Instruction-memory front end that sits directly upstream of the single-cycle RISC-V core and drives its Instr input from the core's PC output. After reset it holds the core in reset. It then receives a program over a byte-wide valid/ready stream and writes it into an internal word memory. When the load completes it releases the core and serves instructions combinationally from that memory.

---
 rtl/riscv_imem_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_imem_loader.sv
// ============================================================================
// Module   : riscv_imem_loader
// Purpose  : Instruction-memory front end for a single-cycle RISC-V core.
//            After reset it holds the core in reset and accepts a program over
//            a byte-wide valid/ready stream:
//              - 16-bit little-endian word count N (low byte first)
//              - N words, each 4 bytes little-endian
//            Once the last word is written it releases the core and serves
//            instructions combinationally from the internal word memory.
//            A count of zero goes straight to RUN. A count larger than the
//            memory goes to an absorbing error state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i         in   1   system clock, rising edge
//   rst_ni        in   1   async active-low reset (release is synchronous)
//   byte_valid_i  in   1   loader stream byte valid
//   byte_data_i   in   8   loader stream byte
//   byte_ready_o  out  1   loader accepts a byte (HDR0/HDR1/LOAD)
//   pc_i          in  32   program counter from the core
//   instr_o       out 32   instruction to the core (combinational)
//   core_reset_o  out  1   active-high core reset, registered
//   load_done_o   out  1   high only in RUN
//   load_err_o    out  1   high only in ERR
// ============================================================================
`default_nettype none

module riscv_imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        core_reset_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [15:0] DEPTH_N   = 16'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [15:0]         word_count_q, word_count_d;
  logic [ADDR_W-1:0]   word_idx_q,   word_idx_d;
  logic [1:0]          byte_idx_q,   byte_idx_d;
  // Only the first three lanes need storage; the fourth byte is taken
  // directly from the stream on the edge the word is written.
  logic [23:0]         asm_q,        asm_d;
  logic                core_reset_q;

  logic [31:0]         mem_q [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                xfer;
  logic [15:0]         hdr_count;
  logic                last_word;
  logic                mem_we;
  logic [31:0]         mem_wdata;

  assign byte_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_LOAD);
  assign xfer         = byte_valid_i && byte_ready_o;

  // Full count as seen while the high header byte is on the bus.
  assign hdr_count    = {byte_data_i, word_count_q[7:0]};

  // LOAD is only entered with 1 <= N <= DEPTH_WORDS, so N-1 never underflows
  // there and always fits the word index.
  assign last_word    = ({{(16-ADDR_W){1'b0}}, word_idx_q} ==
                         (word_count_q - 16'd1));

  assign mem_wdata    = {byte_data_i, asm_q};

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    mem_we       = 1'b0;

    case (state_q)
      S_HDR0: begin
        if (xfer) begin
          word_count_d[7:0] = byte_data_i;
          state_d           = S_HDR1;
        end
      end

      S_HDR1: begin
        if (xfer) begin
          word_count_d[15:8] = byte_data_i;
          if (hdr_count == 16'd0) begin
            state_d = S_RUN;
          end else if (hdr_count > DEPTH_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;  // wraps 3 -> 0 after each word
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              mem_we     = 1'b1;
              word_idx_d = word_idx_q + ADDR_W'(1);
              if (last_word) begin
                state_d = S_RUN;
              end
            end
          endcase
        end
      end

      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_HDR0;
      word_count_q <= 16'd0;
      word_idx_q   <= '0;
      byte_idx_q   <= 2'd0;
      asm_q        <= 24'd0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      // Follows the state one cycle late: the core sees reset drop on the
      // edge after RUN is entered, and never in ERR.
      core_reset_q <= (state_q != S_RUN);
    end
  end

  // Instruction memory: no reset, contents survive a loader reset. Stale
  // words are hidden by the range check on the read side.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[word_idx_q] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read port and status outputs
  // --------------------------------------------------------------------------
  logic [29:0]       pc_word;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_ok;

  assign pc_word = pc_i[31:2];
  assign rd_idx  = pc_i[ADDR_W+1:2];
  // In RUN, N <= DEPTH_WORDS, so pc_word < N guarantees rd_idx is in bounds.
  assign rd_ok   = (state_q == S_RUN) && (pc_i[1:0] == 2'b00) &&
                   (pc_word < {14'd0, word_count_q});

  assign instr_o      = rd_ok ? mem_q[rd_idx] : NOP_INSTR;
  assign core_reset_o = core_reset_q;
  assign load_done_o  = (state_q == S_RUN);
  assign load_err_o   = (state_q == S_ERR);

endmodule

`default_nettype wire
